// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and requester indices for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int DMEM_AW    = 5;
    localparam int DMEM_DW    = 32;
    localparam int DMEM_DEPTH = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_AUX = 1;

    // True when an address falls beyond the implemented words (no wrap-around).
    function automatic logic is_oor(input logic [31:0] addr, input int unsigned depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester/response and memory-port bundle for the data-memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready per requester; responses and memory port have none.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            mem_write;
    logic            mem_read;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    // Arbiter side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_write, mem_read, mem_addr, mem_wdata
    );

    // Requester/memory side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input picker: one-hot grant, round-robin on contention (or fixed CPU priority with DMEM_ARB_FIXED_PRIO_EN).
// Latency: combinational.
// Backpressure: none; grant is zero when no input is valid.
module rr_pick2 (
`ifndef DMEM_ARB_FIXED_PRIO_EN
    input  logic       last_i,
`endif
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    // A lone requester wins outright; contention is resolved by policy.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01: grant_o = 2'b01;
            2'b10: grant_o = 2'b10;
            2'b11: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                grant_o = 2'b01;
`else
                // The requester that was not served last goes next.
                grant_o = last_i ? 2'b01 : 2'b10;
`endif
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory; DMEM_ARB_FIXED_PRIO_EN selects fixed CPU priority.
// Latency: accept in N, memory strobe in N+1, registered response pulse in N+2; one transaction per 2 cycles.
// Backpressure: req_ready only in IDLE to the winner; responses are single-cycle pulses with no backpressure.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW    = DMEM_AW,
    parameter int DW    = DMEM_DW,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    arb_state_t    state_q;
    logic          owner_q;
    logic          we_q;
    logic          oor_q;
    logic          mem_write_q;
    logic          mem_read_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [1:0]    rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;

    logic [1:0]    grant;
    logic          sel;
    logic          we_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;
    logic          oor_sel;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    rr_pick2 u_pick (
        .valid_i (bus.req_valid),
        .grant_o (grant)
    );
`else
    logic rr_last_q;

    rr_pick2 u_pick (
        .last_i  (rr_last_q),
        .valid_i (bus.req_valid),
        .grant_o (grant)
    );

    // Remember who was served last; reset value lets the CPU win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else if (state_q == ACCESS) begin
            rr_last_q <= owner_q;
        end
    end
`endif

    // Winner's payload mux; grant is one-hot so bit 1 is the winner index.
    always_comb begin
        sel       = grant[REQ_AUX];
        we_sel    = bus.req_we[sel];
        addr_sel  = sel ? bus.req_addr[AW +: AW]  : bus.req_addr[0 +: AW];
        wdata_sel = sel ? bus.req_wdata[DW +: DW] : bus.req_wdata[0 +: DW];
        oor_sel   = is_oor(32'(addr_sel), DEPTH);
    end

    assign bus.req_ready = (state_q == IDLE) ? grant : 2'b00;

    assign bus.mem_write = mem_write_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Sequencer: accept in IDLE, drive the memory port for exactly the ACCESS cycle, then respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 2'b00;
                    if (|bus.req_valid) begin
                        owner_q     <= sel;
                        we_q        <= we_sel;
                        oor_q       <= oor_sel;
                        // Out-of-range requests never touch the memory port.
                        mem_write_q <= we_sel & ~oor_sel;
                        mem_read_q  <= ~we_sel & ~oor_sel;
                        mem_addr_q  <= oor_sel ? '0 : addr_sel;
                        mem_wdata_q <= oor_sel ? '0 : wdata_sel;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    // Memory read data is combinational, so capture it on this edge.
                    rsp_rdata_q <= (!we_q && !oor_q) ? bus.mem_rdata : '0;
                    rsp_err_q   <= oor_q;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (32-bit words, 5-bit address, memwrite/memread strobes).
- Port 0 is the CPU load/store stage; port 1 is a secondary master (debug/DMA loader).
- Accepts one transaction at a time with a valid/ready handshake and drives the memory strobes for exactly one cycle.
- Returns a registered response (read data or error) to the winning requester.

Parameters:
- AW, 5, address width of requests and memory port.
- DW, 32, data width.
- DEPTH, 4, number of implemented memory words; addresses >= DEPTH are out of range.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester request valid; bit i = requester i
- req_ready  output  2  per-requester accept; one-hot or zero
- req_we  input  2  per-requester 1=write, 0=read
- req_addr  input  2*AW  requester i at [i*AW +: AW]
- req_wdata  input  2*DW  requester i at [i*DW +: DW]
- rsp_valid  output  2  one-cycle response pulse to the owning requester
- rsp_rdata  output  DW  read data, shared; valid only with rsp_valid
- rsp_err  output  1  out-of-range flag, qualified by rsp_valid
- mem_write  output  1  to memory memwrite
- mem_read  output  1  to memory memread
- mem_addr  output  AW  to memory address
- mem_wdata  output  DW  to memory DataIn
- mem_rdata  input  DW  from memory read data; combinational, valid in the same cycle as mem_read

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_last=1 (requester 0 wins first tie).
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - If any req_valid is set, select a winner; req_ready[winner]=1 combinationally in that cycle.
  - On the edge: latch we/addr/wdata/owner, set oor = (addr >= DEPTH), go to ACCESS.
  - With no request, remain in IDLE.
- ACCESS (exactly one cycle):
  - If !oor: mem_write=we, mem_read=!we, mem_addr and mem_wdata from the latched values.
  - If oor: both strobes stay 0 and the memory is not touched.
  - On the edge: rsp_rdata <= (read && !oor) ? mem_rdata : 0; rsp_err <= oor; rsp_valid[owner] <= 1; rr_last <= owner; go to IDLE.
- Latency: accept in cycle N, memory access in N+1, rsp_valid in N+2.
  - The cycle N+2 is IDLE again, so a new accept may coincide with the response.
  - Peak throughput: one transaction per 2 cycles.
- req_ready is 0 throughout ACCESS.
- Requesters must hold valid and payload stable until ready.
- Arbitration: round-robin; on contention the requester != rr_last wins. A lone request wins immediately.
- rsp_valid is a single-cycle pulse with no backpressure; requesters must sample it.
- Write responses: rsp_valid pulses with rsp_rdata=0.
- Mem outputs are 0 whenever not in ACCESS.
- Simultaneous requests to the same address: serialized in grant order. A read after a write returns the written data.
- Reset asserted mid-ACCESS: the strobes drop immediately, no response is issued, and the transaction is lost.
- Address wrap: none. Only the range check applies; addresses DEPTH..2^AW-1 return rsp_err=1.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 (CPU) always wins contention; rr_last is not implemented. Requester 1 may starve and this is accepted.
- Undefined: round-robin as above.
- Latency and handshake are identical in both modes.

Decomposition:
- Shared package dmem_pkg holds:
  - Constants DMEM_AW=5, DMEM_DW=32, DMEM_DEPTH=4.
  - State enum arb_state_t {IDLE, ACCESS}.
  - Requester index constants REQ_CPU=0, REQ_AUX=1.
- One sub-module, rr_pick2: 2-input round-robin/fixed-priority picker. Inputs valid[1:0] and last. Outputs a one-hot grant. The macro switches its behaviour.

Test Plan:
- Single write then read: r0 writes 0xDEADBEEF @2, then reads @2 -> mem_write for 1 cycle at N+1; read rsp_valid[0] at N+2 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Contention: both valid continuously after reset, both reading @1 -> grants alternate 0,1,0,1; rsp_valid pulses every 2 cycles to the matching bit. With DMEM_ARB_FIXED_PRIO_EN, only r0 is granted.
- Out of range: r1 reads @4 -> no mem_read strobe; rsp_valid[1]=1, rsp_err=1, rsp_rdata=0.
- Write/read ordering: r0 writes 0x12345678 @3 while r1 requests a read @3 in the same cycle -> r0 granted first; r1 response = 0x12345678.
- Back-to-back: r0 valid every cycle -> req_ready high every other cycle. The next accept coincides with the previous rsp_valid cycle.
- Reset mid-ACCESS: rst_n low during ACCESS -> mem strobes drop the same cycle; no rsp_valid after release; the next request is served normally.
